key_matrix_emu: RTL and testbench

KEY_MATRIX_EMU -- requirements
Module: key_matrix_emu

---
 rtl/key_matrix_emu.sv | 119 +++++++++++
 tb/tb_key_matrix_emu.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_matrix_emu.sv
// Keypad matrix emulator: queued key requests are "pressed" by pulling the
// requested column low whenever the scanner drives the key's row, held for
// HOLD_CYCLES and followed by a GAP_CYCLES forced release.
module key_matrix_emu #(
    parameter int HOLD_CYCLES = 64,
    parameter int GAP_CYCLES  = 64,
    parameter int DEPTH       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hl,
    output logic [3:0] vl,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       busy,
    output logic       done,
    output logic [4:0] level
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    state_t        state, state_nxt;
    logic [15:0]   cnt, cnt_nxt;
    logic [3:0]    act, act_nxt;
    logic [3:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;

    assign key_ready = (level != 5'(DEPTH));
    assign push      = key_valid & key_ready;
    // The FSM only takes a new key from IDLE, so a pop never hits the slot
    // being written in the same cycle (level would be 0).
    assign pop       = (state == IDLE) && (level != 5'd0);

    // Queue pointers and occupancy; pointers wrap naturally (DEPTH is 2^PW).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 5'd1;
                2'b01:   level <= level - 5'd1;
                default: ;
            endcase
        end
    end

    // Queue storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= key_code;
    end

    // FSM state, dwell counter and active key registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            act   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            act   <= act_nxt;
        end
    end

    // Next-state: counter holds the remaining cycles of the current phase,
    // so a phase loaded with N lasts exactly N cycles (terminal count is 1).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        act_nxt   = act;
        case (state)
            IDLE: begin
                if (pop) begin
                    act_nxt   = mem[rd_ptr];
                    cnt_nxt   = 16'(HOLD_CYCLES);
                    state_nxt = PRESS;
                end
            end
            PRESS: begin
                if (cnt == 16'd1) begin
                    cnt_nxt   = 16'(GAP_CYCLES);
                    state_nxt = GAP;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            GAP: begin
                if (cnt == 16'd1) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign done = (state == GAP) && (cnt == 16'd1);
    assign busy = (state != IDLE) || (level != 5'd0);

    // Column sense: only the active key's column, only while its row is driven.
    always_comb begin
        vl = 4'b1111;
        if ((state == PRESS) && !hl[act[3:2]]) vl[act[1:0]] = 1'b0;
    end

endmodule

// File: tb/tb_key_matrix_emu.sv
// Directed bench for key_matrix_emu with HOLD=4, GAP=3, DEPTH=4.
module tb_key_matrix_emu;

    logic       clk;
    logic       rst;
    logic [3:0] hl;
    logic [3:0] vl;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       busy;
    logic       done;
    logic [4:0] level;

    int n_chk  = 0;
    int n_fail = 0;

    key_matrix_emu #(.HOLD_CYCLES(4), .GAP_CYCLES(3), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .hl        (hl),
        .vl        (vl),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .busy      (busy),
        .done      (done),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vl_active(input string tag);
        int n = 0;
        while (vl === 4'b1111 && n < 40) begin step(); n++; end
        chk({tag, "_press_timeout"}, 16'(n < 40), 16'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin step(); n++; end
        chk({tag, "_done_timeout"}, 16'(n < 40), 16'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin step(); n++; end
        chk({tag, "_idle_timeout"}, 16'(n < 200), 16'd1);
    endtask

    initial begin
        int         done_cnt;
        logic [3:0] code;
        logic [3:0] exp4;

        rst       = 1'b0;
        hl        = 4'b0000;
        key_valid = 1'b0;
        key_code  = 4'h0;

        // Reset state while clock runs
        step(); step();
        chk("rst_vl",    vl,        4'b1111);
        chk("rst_ready", key_ready, 1'b1);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_done",  done,      1'b0);
        chk("rst_level", level,     5'd0);
        rst = 1'b1;
        step();

        // Single key 4'b1101, hl=0111
        hl        = 4'b0111;
        key_valid = 1'b1;
        key_code  = 4'b1101;
        step();
        key_valid = 1'b0;
        key_code  = 4'b0000;  // later changes must not affect the queued key
        chk("single_lvl1", level, 5'd1);
        chk("single_vl_pre", vl, 4'b1111);
        chk("single_busy_q", busy, 1'b1);
        step();
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("single_vl_%0d", k),   vl,    (k < 4) ? 4'b1101 : 4'b1111);
            chk($sformatf("single_done_%0d", k), done,  (k == 6) ? 1'b1 : 1'b0);
            chk($sformatf("single_busy_%0d", k), busy,  1'b1);
            chk($sformatf("single_lvl_%0d", k),  level, 5'd0);
            step();
        end
        chk("single_end_vl",   vl,   4'b1111);
        chk("single_end_done", done, 1'b0);
        chk("single_end_busy", busy, 1'b0);

        // Row mismatch: code 4'b1101 (row 3, col 1)
        key_valid = 1'b1;
        key_code  = 4'b1101;
        step();
        key_valid = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            hl = ~(4'b0001 << k);
            #1;
            chk($sformatf("rowmis_vl_%0d", k), vl, (k == 3) ? 4'b1101 : 4'b1111);
            step();
        end
        hl = 4'b0111;
        #1;
        chk("rowmis_gap_vl", vl, 4'b1111);
        wait_idle("rowmis");

        // Fill/overflow while a key (4'hF) is pressed
        hl        = 4'b1110;
        key_valid = 1'b1;
        key_code  = 4'hF;
        step();
        key_valid = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            key_valid = 1'b1;
            key_code  = 4'(i);
            step();
            chk($sformatf("fill_lvl_%0d", i),   level,     (i < 4) ? 5'(i + 1) : 5'd4);
            chk($sformatf("fill_ready_%0d", i), key_ready, (i < 3) ? 1'b1 : 1'b0);
        end
        key_valid = 1'b0;
        done_cnt  = 0;
        for (int j = 0; j < 4; j++) begin
            wait_vl_active($sformatf("fill_key%0d", j));
            exp4 = ~(4'b0001 << j);
            chk($sformatf("fill_order_%0d", j), vl, exp4);
            wait_done($sformatf("fill_key%0d", j));
            if (done === 1'b1) done_cnt++;
        end
        wait_idle("fill");
        chk("fill_done_cnt", 16'(done_cnt), 16'd4);
        chk("fill_lvl_end",  level, 5'd0);

        // Push/pop collision at the IDLE pop edge with a full queue
        key_valid = 1'b1;
        key_code  = 4'h1;
        step();
        key_valid = 1'b0;
        step();
        for (int i = 4; i < 8; i++) begin
            key_valid = 1'b1;
            key_code  = 4'(i);
            step();
        end
        chk("coll_lvl_full", level, 5'd4);
        key_code = 4'h9;  // key_valid stays high throughout
        wait_done("coll");
        step();
        chk("coll_lvl_idle",   level,     5'd4);
        chk("coll_ready_idle", key_ready, 1'b0);
        step();
        chk("coll_lvl_pop",   level,     5'd3);
        chk("coll_ready_pop", key_ready, 1'b1);
        step();
        key_valid = 1'b0;
        chk("coll_lvl_retry", level, 5'd4);
        wait_idle("coll");
        chk("coll_lvl_end", level, 5'd0);

        // Reset during PRESS of code 0 with a queued key
        hl        = 4'b1110;
        key_valid = 1'b1;
        key_code  = 4'h0;
        step();
        key_valid = 1'b0;
        step();
        chk("rstmid_vl_press", vl, 4'b1110);
        key_valid = 1'b1;
        key_code  = 4'h2;
        step();
        key_valid = 1'b0;
        chk("rstmid_lvl_q", level, 5'd1);
        chk("rstmid_vl_hold", vl, 4'b1110);
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_vl_async", vl,        4'b1111);
        chk("rstmid_lvl",      level,     5'd0);
        chk("rstmid_ready",    key_ready, 1'b1);
        chk("rstmid_busy",     busy,      1'b0);
        step(); step();
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("post_rst_done_%0d", k), done, 1'b0);
            chk($sformatf("post_rst_vl_%0d", k),   vl,   4'b1111);
        end
        chk("post_rst_busy", busy, 1'b0);

        // Wrap-around: ten keys one at a time
        for (int k = 0; k < 10; k++) begin
            code      = 4'((k * 5 + 2) % 16);
            hl        = ~(4'b0001 << code[3:2]);
            key_valid = 1'b1;
            key_code  = code;
            step();
            key_valid = 1'b0;
            step();
            exp4 = ~(4'b0001 << code[1:0]);
            chk($sformatf("wrap_vl_%0d", k), vl, exp4);
            wait_idle($sformatf("wrap_%0d", k));
        end
        chk("wrap_lvl_end", level, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
